// File: rtl/mem_responder_if.sv
// Load/store request bus between a CPU data port and mem_responder.
// enable is the request valid; the responder is ready whenever busy is low (IDLE or RESP),
// so a request transfers on any rising edge where enable=1 and busy=0. data_valid pulses once per transfer.
interface mem_responder_if;
  logic        enable;
  logic        wr;
  logic [15:0] addr;
  logic [15:0] data_in;
  logic [15:0] data_out;
  logic        data_valid;
  logic        busy;

  modport master (
    output enable, wr, addr, data_in,
    input  data_out, data_valid, busy
  );

  modport slave (
    input  enable, wr, addr, data_in,
    output data_out, data_valid, busy
  );
endinterface

// File: rtl/mem_responder.sv
// Multi-cycle data memory: accepts one load/store, waits LATENCY cycles, then completes it
// with a single data_valid pulse. Requests arriving while busy are dropped, not queued.
module mem_responder #(
  parameter int DEPTH     = 1024,
  parameter int LATENCY   = 4,
  parameter     INIT_FILE = ""
) (
  input  logic             clk,
  input  logic             rst,
  mem_responder_if.slave   bus,
  output logic [1:0]       dbg_state
);

  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t             state;
  logic [3:0]         count;
  logic               req_wr;
  logic [IDX_W-1:0]   req_idx;
  logic [15:0]        req_data;
  logic [15:0]        rd_data;
  logic               valid_q;
  logic               busy_q;
  logic               commit;
  logic               unused_addr;

  logic [15:0] mem [DEPTH];

  // Upper address bits alias onto the same word; they are deliberately ignored.
  assign unused_addr = ^bus.addr;

  assign commit = (state == WAIT) && (count == 4'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      count    <= 4'd0;
      req_wr   <= 1'b0;
      req_idx  <= '0;
      req_data <= 16'h0000;
      rd_data  <= 16'h0000;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      case (state)
        IDLE, RESP: begin
          if (bus.enable) begin
            req_wr   <= bus.wr;
            req_idx  <= bus.addr[IDX_W-1:0];
            req_data <= bus.data_in;
            count    <= 4'(LATENCY - 1);
            state    <= WAIT;
            busy_q   <= 1'b1;
            valid_q  <= 1'b0;
          end else begin
            state    <= IDLE;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
          end
        end
        WAIT: begin
          if (count == 4'd0) begin
            state   <= RESP;
            busy_q  <= 1'b0;
            valid_q <= 1'b1;
            if (!req_wr) rd_data <= mem[req_idx];
          end else begin
            count <= count - 4'd1;
          end
        end
        default: begin
          state   <= IDLE;
          busy_q  <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  // The array has no reset; a write reset out of WAIT never reaches commit.
  always_ff @(posedge clk) begin
    if (commit && req_wr) mem[req_idx] <= req_data;
  end

  assign bus.data_out   = rd_data;
  assign bus.data_valid = valid_q;
  assign bus.busy       = busy_q;
  assign dbg_state      = state;

endmodule

// File: tb/tb_mem_responder.sv
// Randomized and directed bench for mem_responder at LATENCY=4 and LATENCY=1, checked
// against a cycle-numbered transaction model with its own memory image.
module tb_mem_responder;

  localparam int DEPTH = 1024;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_responder_if bus0();
  mem_responder_if bus1();
  logic [1:0] st0, st1;

  mem_responder #(.DEPTH(DEPTH), .LATENCY(4)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0), .dbg_state(st0)
  );
  mem_responder #(.DEPTH(DEPTH), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1), .dbg_state(st1)
  );

  int checks = 0;
  int errors = 0;

  // Model: request accepted at edge e completes at edge e+lat; next acceptance from e+lat+1.
  int          lat [2] = '{4, 1};
  int          cyc = 0;
  bit          pend [2];
  int          done_e [2];
  int          free_e [2];
  bit          pend_wr [2];
  int          pend_idx [2];
  logic [15:0] pend_data [2];
  logic [15:0] ref_mem [2][DEPTH];
  logic [15:0] exp_out [2];
  logic [15:0] exp_q [$];
  int          acc_cnt = 0;
  int          dv_cnt = 0;
  bit          last_acc = 0;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input int sel, input bit en, input bit w, input logic [15:0] a,
                       input logic [15:0] d);
    bus0.enable  = (sel == 0) && en;
    bus1.enable  = (sel == 1) && en;
    bus0.wr      = w;
    bus1.wr      = w;
    bus0.addr    = a;
    bus1.addr    = a;
    bus0.data_in = d;
    bus1.data_in = d;
  endtask

  task automatic step(input int sel, input bit en, input bit w, input logic [15:0] a,
                      input logic [15:0] d);
    bit          exp_dv;
    logic        busy_s, dv_s;
    logic [15:0] dout_s;
    drive(sel, en, w, a, d);
    @(posedge clk);
    cyc++;
    exp_dv   = 1'b0;
    last_acc = 1'b0;
    if (pend[sel] && cyc == done_e[sel]) begin
      if (pend_wr[sel]) ref_mem[sel][pend_idx[sel]] = pend_data[sel];
      else if (exp_q.size() > 0) exp_out[sel] = exp_q.pop_front();
      pend[sel] = 1'b0;
      exp_dv    = 1'b1;
    end
    if (en && cyc >= free_e[sel]) begin
      pend[sel]      = 1'b1;
      done_e[sel]    = cyc + lat[sel];
      free_e[sel]    = cyc + lat[sel] + 1;
      pend_wr[sel]   = w;
      pend_idx[sel]  = int'(a) % DEPTH;
      pend_data[sel] = d;
      if (!w) exp_q.push_back(ref_mem[sel][int'(a) % DEPTH]);
      acc_cnt++;
      last_acc = 1'b1;
    end
    @(negedge clk);
    busy_s = (sel == 0) ? bus0.busy       : bus1.busy;
    dv_s   = (sel == 0) ? bus0.data_valid : bus1.data_valid;
    dout_s = (sel == 0) ? bus0.data_out   : bus1.data_out;
    chk("busy", {15'b0, busy_s}, {15'b0, (pend[sel] && cyc < done_e[sel])});
    chk("data_valid", {15'b0, dv_s}, {15'b0, exp_dv});
    chk("data_out", dout_s, exp_out[sel]);
    if (dv_s === 1'b1) dv_cnt++;
  endtask

  task automatic issue(input int sel, input bit w, input logic [15:0] a, input logic [15:0] d);
    for (int i = 0; i < 40; i++) begin
      step(sel, 1'b1, w, a, d);
      if (last_acc) return;
    end
    chk("issue_timeout", 16'd0, 16'd1);
  endtask

  task automatic wait_done(input int sel);
    for (int i = 0; i < 40; i++) begin
      if (!pend[sel]) return;
      step(sel, 1'b0, 1'b0, 16'h0, 16'h0);
    end
    chk("done_timeout", 16'd0, 16'd1);
  endtask

  task automatic do_reset();
    #2;
    rst = 1'b1;
    drive(0, 1'b0, 1'b0, 16'h0, 16'h0);
    #1;
    chk("rst_busy0", {15'b0, bus0.busy}, 16'd0);
    chk("rst_dv0", {15'b0, bus0.data_valid}, 16'd0);
    chk("rst_dout0", bus0.data_out, 16'h0000);
    chk("rst_busy1", {15'b0, bus1.busy}, 16'd0);
    chk("rst_dv1", {15'b0, bus1.data_valid}, 16'd0);
    chk("rst_dout1", bus1.data_out, 16'h0000);
    for (int s = 0; s < 2; s++) begin
      pend[s]    = 1'b0;
      exp_out[s] = 16'h0000;
      free_e[s]  = 0;
    end
    exp_q.delete();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic random_run(input int sel);
    bit          en, w;
    logic [15:0] a, d;
    for (int i = 0; i < 8; i++) begin
      issue(sel, 1'b1, 16'(i), 16'($urandom));
      wait_done(sel);
    end
    acc_cnt = 0;
    dv_cnt  = 0;
    for (int i = 0; i < 60; i++) begin
      en = ($urandom_range(0, 99) < 60);
      w  = 1'($urandom_range(0, 1));
      a  = (16'($urandom_range(0, 63)) << 10) | 16'($urandom_range(0, 7));
      d  = 16'($urandom);
      step(sel, en, w, a, d);
    end
    wait_done(sel);
    chk("completion_count", 16'(dv_cnt), 16'(acc_cnt));
  endtask

  initial begin
    int n_acc;
    bit nw;
    drive(0, 1'b0, 1'b0, 16'h0, 16'h0);
    do_reset();

    // Write then read-back with exact latency timing.
    issue(0, 1'b1, 16'h0010, 16'hBEEF);
    wait_done(0);
    issue(0, 1'b0, 16'h0010, 16'h0000);
    wait_done(0);
    chk("readback", bus0.data_out, 16'hBEEF);

    // A write presented during WAIT is dropped.
    issue(0, 1'b0, 16'h0010, 16'h0000);
    for (int i = 0; i < 3; i++) step(0, 1'b1, 1'b1, 16'h0010, 16'h1234);
    wait_done(0);
    chk("ignored_write_a", bus0.data_out, 16'hBEEF);
    issue(0, 1'b0, 16'h0010, 16'h0000);
    wait_done(0);
    chk("ignored_write_b", bus0.data_out, 16'hBEEF);

    // Reset in the middle of a write discards it.
    issue(0, 1'b1, 16'h0020, 16'h1111);
    wait_done(0);
    issue(0, 1'b1, 16'h0020, 16'h5555);
    step(0, 1'b0, 1'b0, 16'h0, 16'h0);
    do_reset();
    issue(0, 1'b0, 16'h0020, 16'h0000);
    wait_done(0);
    chk("reset_discard", bus0.data_out, 16'h1111);

    // Address aliasing above the index width.
    issue(0, 1'b1, 16'h0400, 16'hA5A5);
    wait_done(0);
    issue(0, 1'b0, 16'h0000, 16'h0000);
    wait_done(0);
    chk("alias", bus0.data_out, 16'hA5A5);

    // LATENCY=1 with enable held: one acceptance every two cycles.
    issue(1, 1'b1, 16'h0003, 16'h0F0F);
    nw    = 1'b0;
    n_acc = 0;
    for (int i = 0; i < 8; i++) begin
      step(1, 1'b1, nw, 16'h0003, 16'h0F0F);
      if (last_acc) begin
        n_acc++;
        nw = ~nw;
      end
    end
    wait_done(1);
    chk("l1_accepts", 16'(n_acc), 16'd4);
    chk("l1_read", bus1.data_out, 16'h0F0F);

    random_run(0);
    random_run(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
